// File: rtl/bullet_pkg.sv
// Shared types, screen limits and spawn/motion helpers for the bullet swarm.
// A bullet's per-axis motion state is one pos/dir pair stepped by axis_step.
package bullet_pkg;

  typedef enum logic {NEG = 1'b0, POS = 1'b1} dir_t;

  typedef struct packed {
    logic [9:0] pos;
    dir_t       dir;
  } axis_t;

  localparam int H_LAST = 639;
  localparam int V_LAST = 479;

  function automatic int spawn_x(int i, int n, int xmin, int xmax);
    return xmin + ((i + 1) * (xmax - xmin)) / (n + 1);
  endfunction

  // One frame of motion on one axis. Compared in 11 bits so pos+step never wraps.
  function automatic axis_t axis_step(axis_t a, int lo, int hi, int speed, int radius);
    axis_t       r;
    logic [10:0] p;
    r = a;
    p = {1'b0, a.pos};
    if (a.dir == NEG) begin
      if (p <= 11'(lo + speed)) begin
        r.pos = 10'(lo);
        r.dir = POS;
      end else begin
        r.pos = a.pos - 10'(speed);
      end
    end else begin
      if (p + 11'(speed + radius) >= 11'(hi)) begin
        r.pos = 10'(hi - radius);
        r.dir = NEG;
      end else begin
        r.pos = a.pos + 10'(speed);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bullet_swarm_if.sv
// Game-side bus of the bullet swarm: scan position, game state and collision in,
// registered lit flag and alive status out. Plain level signals, no handshake.
interface bullet_swarm_if #(parameter int N_BULLETS = 4);
  logic [3:0]           state;
  logic [9:0]           x;
  logic [9:0]           y;
  logic                 collision;
  logic                 bullet_on;
  logic [N_BULLETS-1:0] alive_mask;
  logic                 all_clear;

  modport master (output state, x, y, collision,
                  input  bullet_on, alive_mask, all_clear);
  modport slave  (input  state, x, y, collision,
                  output bullet_on, alive_mask, all_clear);
endinterface

// File: rtl/bullet_unit.sv
// One bullet: position/direction registers, alive flag, wall bounce once per
// frame and a combinational circle hit test against the current scan pixel.
module bullet_unit
  import bullet_pkg::*;
#(
  parameter int   X0     = 200,
  parameter int   Y0     = 240,
  parameter dir_t DIR0   = NEG,
  parameter int   RADIUS = 4,
  parameter int   SPEED  = 5,
  parameter int   X_MIN  = 120,
  parameter int   X_MAX  = 520,
  parameter int   Y_MIN  = 100,
  parameter int   Y_MAX  = 380
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic       frame_end,
  input  logic       kill,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       alive,
  output logic       hit
);

  localparam axis_t       X_INIT = '{pos: 10'(X0), dir: DIR0};
  localparam axis_t       Y_INIT = '{pos: 10'(Y0), dir: DIR0};
  localparam logic [22:0] R_SQ   = 23'(RADIUS * RADIUS);

  axis_t              xa, ya;
  logic signed [10:0] dx, dy;
  logic signed [21:0] dx2, dy2;
  logic [22:0]        dist2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xa    <= X_INIT;
      ya    <= Y_INIT;
      alive <= 1'b1;
    end else if (!active) begin
      xa    <= X_INIT;
      ya    <= Y_INIT;
      alive <= 1'b1;
    end else if (kill) begin
      // A bullet killed on the frame-end cycle stays where it was hit.
      alive <= 1'b0;
    end else if (frame_end && alive) begin
      xa <= axis_step(xa, X_MIN, X_MAX, SPEED, RADIUS);
      ya <= axis_step(ya, Y_MIN, Y_MAX, SPEED, RADIUS);
    end
  end

  assign dx    = $signed({1'b0, x}) - $signed({1'b0, xa.pos});
  assign dy    = $signed({1'b0, y}) - $signed({1'b0, ya.pos});
  assign dx2   = 22'(dx) * 22'(dx);
  assign dy2   = 22'(dy) * 22'(dy);
  assign dist2 = {1'b0, dx2} + {1'b0, dy2};
  assign hit   = alive && (dist2 <= R_SQ);

endmodule

// File: rtl/bullet_swarm.sv
// Multi-bullet sprite generator for the battle box: N bouncing bullets, a
// registered per-pixel lit flag, per-bullet kill on heart collision.
module bullet_swarm
  import bullet_pkg::*;
#(
  parameter int         N_BULLETS    = 4,
  parameter int         RADIUS       = 4,
  parameter int         SPEED        = 5,
  parameter int         X_MIN        = 120,
  parameter int         X_MAX        = 520,
  parameter int         Y_MIN        = 100,
  parameter int         Y_MAX        = 380,
  parameter logic [3:0] ACTIVE_STATE = 4'd1
) (
  input logic           clk,
  input logic           rst_n,
  bullet_swarm_if.slave bus
);

  logic                 active;
  logic                 frame_end;
  logic [N_BULLETS-1:0] hit, hit_q, kill, alive, alive_next;
  logic                 bullet_on_q;
  logic                 all_clear_q;

  assign active    = (bus.state == ACTIVE_STATE);
  assign frame_end = (bus.x == 10'(H_LAST)) && (bus.y == 10'(V_LAST));
  // collision refers to the pixel registered last cycle, hence hit_q.
  assign kill       = (active && bus.collision) ? hit_q : '0;
  assign alive_next = active ? (alive & ~kill) : '1;

  for (genvar i = 0; i < N_BULLETS; i++) begin : g_bullet
    bullet_unit #(
      .X0     (spawn_x(i, N_BULLETS, X_MIN, X_MAX)),
      .Y0     ((Y_MIN + Y_MAX) / 2),
      .DIR0   ((i % 2 == 0) ? NEG : POS),
      .RADIUS (RADIUS),
      .SPEED  (SPEED),
      .X_MIN  (X_MIN),
      .X_MAX  (X_MAX),
      .Y_MIN  (Y_MIN),
      .Y_MAX  (Y_MAX)
    ) u_unit (
      .clk       (clk),
      .rst_n     (rst_n),
      .active    (active),
      .frame_end (frame_end),
      .kill      (kill[i]),
      .x         (bus.x),
      .y         (bus.y),
      .alive     (alive[i]),
      .hit       (hit[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q       <= '0;
      bullet_on_q <= 1'b0;
      all_clear_q <= 1'b0;
    end else begin
      hit_q       <= active ? hit : '0;
      bullet_on_q <= active && (|hit);
      all_clear_q <= (alive_next == '0);
    end
  end

  assign bus.bullet_on  = bullet_on_q;
  assign bus.alive_mask = alive;
  assign bus.all_clear  = all_clear_q;

endmodule

// File: tb/tb_bullet_swarm.sv
// Directed bench for bullet_swarm with default parameters: spawn x = 200/280/360/440,
// spawn y = 240; expected values are hand-computed from the motion and hit rules.
module tb_bullet_swarm;

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   pass_cnt;
  int   fail_cnt;

  bullet_swarm_if #(.N_BULLETS(4)) bus ();

  bullet_swarm #(.N_BULLETS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: one pixel per clock, outputs sampled 1 time unit after the edge
  task automatic step(input int px, input int py, input logic coll);
    @(negedge clk);
    bus.x         = 10'(px);
    bus.y         = 10'(py);
    bus.collision = coll;
    @(posedge clk);
    #1;
  endtask

  task automatic set_state(input logic [3:0] s);
    @(negedge clk);
    bus.state = s;
  endtask

  task automatic respawn();
    set_state(4'd0);
    step(0, 0, 1'b0);
    set_state(4'd1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    total_cnt     = 0;
    pass_cnt      = 0;
    fail_cnt      = 0;
    rst_n         = 1'b0;
    bus.state     = 4'd0;
    bus.x         = 10'd0;
    bus.y         = 10'd0;
    bus.collision = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_bullet_on", 32'(bus.bullet_on), 32'd0);
    check("rst_alive", 32'(bus.alive_mask), 32'hF);
    check("rst_all_clear", 32'(bus.all_clear), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_state(4'd1);
    step(0, 0, 1'b0);
    check("idle_bullet_on", 32'(bus.bullet_on), 32'd0);
    check("idle_alive", 32'(bus.alive_mask), 32'hF);
    check("idle_all_clear", 32'(bus.all_clear), 32'd0);

    // hit test around spawn positions
    step(200, 240, 1'b0); check("hit_centre_b0", 32'(bus.bullet_on), 32'd1);
    step(204, 240, 1'b0); check("hit_edge_r4", 32'(bus.bullet_on), 32'd1);
    step(205, 240, 1'b0); check("miss_r5", 32'(bus.bullet_on), 32'd0);
    step(203, 243, 1'b0); check("miss_d18", 32'(bus.bullet_on), 32'd0);
    step(440, 236, 1'b0); check("hit_top_b3", 32'(bus.bullet_on), 32'd1);

    // one frame end: b0 -> (195,235), b1 -> (285,245)
    step(639, 479, 1'b0); check("frame_end_dark", 32'(bus.bullet_on), 32'd0);
    step(195, 235, 1'b0); check("b0_moved", 32'(bus.bullet_on), 32'd1);
    step(285, 245, 1'b0); check("b1_moved", 32'(bus.bullet_on), 32'd1);
    step(200, 240, 1'b0); check("b0_old_dark", 32'(bus.bullet_on), 32'd0);

    // 16 frames from spawn: b0 at (120,160) heading POS
    respawn();
    for (int f = 0; f < 16; f++) step(639, 479, 1'b0);
    step(120, 160, 1'b0); check("b0_at_xmin", 32'(bus.bullet_on), 32'd1);
    step(125, 160, 1'b0); check("b0_not_125", 32'(bus.bullet_on), 32'd0);
    step(639, 479, 1'b0);
    step(125, 155, 1'b0); check("b0_bounced", 32'(bus.bullet_on), 32'd1);
    step(120, 155, 1'b0); check("b0_left_wall", 32'(bus.bullet_on), 32'd0);
    // b3 bounced off the right wall at 516 and stepped back to 511
    step(511, 325, 1'b0); check("b3_bounced", 32'(bus.bullet_on), 32'd1);

    // kill bullet1, then the rest
    respawn();
    step(280, 240, 1'b0); check("b1_lit", 32'(bus.bullet_on), 32'd1);
    step(0, 0, 1'b1);
    check("kill_b1_mask", 32'(bus.alive_mask), 32'hD);
    check("kill_b1_clear", 32'(bus.all_clear), 32'd0);
    step(280, 240, 1'b0);
    step(280, 240, 1'b0); check("b1_dead_dark", 32'(bus.bullet_on), 32'd0);
    step(200, 240, 1'b0); step(0, 0, 1'b1);
    check("kill_b0_mask", 32'(bus.alive_mask), 32'hC);
    step(360, 240, 1'b0); step(0, 0, 1'b1);
    check("kill_b2_mask", 32'(bus.alive_mask), 32'h8);
    check("kill_b2_clear", 32'(bus.all_clear), 32'd0);
    step(440, 240, 1'b0); step(0, 0, 1'b1);
    check("kill_all_mask", 32'(bus.alive_mask), 32'h0);
    check("kill_all_clear", 32'(bus.all_clear), 32'd1);

    // leaving and re-entering the fight re-arms everything at spawn
    set_state(4'd0);
    step(200, 240, 1'b0);
    check("inactive_mask", 32'(bus.alive_mask), 32'hF);
    check("inactive_clear", 32'(bus.all_clear), 32'd0);
    check("inactive_dark", 32'(bus.bullet_on), 32'd0);
    set_state(4'd1);
    step(200, 240, 1'b0); check("rearm_b0_spawn", 32'(bus.bullet_on), 32'd1);

    // collision on the frame-end cycle hits bullet2; others advance
    respawn();
    step(360, 240, 1'b0); check("b2_lit", 32'(bus.bullet_on), 32'd1);
    step(639, 479, 1'b1);
    check("fe_kill_mask", 32'(bus.alive_mask), 32'hB);
    step(355, 235, 1'b0); check("b2_not_moved", 32'(bus.bullet_on), 32'd0);
    step(360, 240, 1'b0); check("b2_dead_dark", 32'(bus.bullet_on), 32'd0);
    step(195, 235, 1'b0); check("fe_b0_moved", 32'(bus.bullet_on), 32'd1);
    step(285, 245, 1'b0); check("fe_b1_moved", 32'(bus.bullet_on), 32'd1);
    step(445, 245, 1'b0); check("fe_b3_moved", 32'(bus.bullet_on), 32'd1);

    // asynchronous reset mid-frame
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_on", 32'(bus.bullet_on), 32'd0);
    check("async_rst_mask", 32'(bus.alive_mask), 32'hF);
    check("async_rst_clear", 32'(bus.all_clear), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(200, 240, 1'b0); check("post_rst_b0", 32'(bus.bullet_on), 32'd1);

    // report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
